// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES decryption core: one inverse round per clock over a single 128-bit state register.
// Latency: NR clock edges from the accept edge to out_valid. A new block can start every NR+2 cycles.
// Backpressure: the plaintext is held in DONE until out_ready; in_ready stays low from accept until the output handshake.
// Ports: clk/rst (async active-high); in_valid/in_ready/in_data carry the ciphertext;
//        rk_idx/rk form the round-key lookup into the external key store (rk returns in the same cycle);
//        out_valid/out_ready/out_data carry the plaintext.

// Inverse ShiftRows: row r of the column-major state is rotated right by r.
module inv_shift_rows (
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);
  always_comb begin
    state_o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        state_o[127-8*(4*c+r) -: 8] = state_i[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
  end
endmodule

// Inverse SubBytes: 16 parallel lookups into the inverse S-box.
module inv_sub_bytes (
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);
  // Entry 0 is the most significant byte of the constant.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  always_comb begin
    state_o = '0;
    for (int i = 0; i < 16; i++) begin
      state_o[127-8*i -: 8] = INV_SBOX[state_i[127-8*i -: 8]];
    end
  end
endmodule

// Inverse MixColumns: each column multiplied by the circulant {0e,0b,0d,09} over GF(2^8), poly 0x11b.
module inv_mix_columns (
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m09(input logic [7:0] x);
    return xt(xt(xt(x))) ^ x;
  endfunction

  function automatic logic [7:0] m0b(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(x) ^ x;
  endfunction

  function automatic logic [7:0] m0d(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
  endfunction

  function automatic logic [7:0] m0e(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
  endfunction

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    state_o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = state_i[127-32*c -: 8];
      a1 = state_i[119-32*c -: 8];
      a2 = state_i[111-32*c -: 8];
      a3 = state_i[103-32*c -: 8];
      state_o[127-32*c -: 8] = m0e(a0) ^ m0b(a1) ^ m0d(a2) ^ m09(a3);
      state_o[119-32*c -: 8] = m09(a0) ^ m0e(a1) ^ m0b(a2) ^ m0d(a3);
      state_o[111-32*c -: 8] = m0d(a0) ^ m09(a1) ^ m0e(a2) ^ m0b(a3);
      state_o[103-32*c -: 8] = m0b(a0) ^ m0d(a1) ^ m09(a2) ^ m0e(a3);
    end
  end
endmodule

// AddRoundKey: plain XOR, shared by encryption and decryption.
module add_round_key (
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  output logic [127:0] state_o
);
  assign state_o = state_i ^ key_i;
endmodule

module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR4 = 4'(NR);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  state_e         state_q;
  logic [3:0]     cnt_q;
  logic [3:0]     rk_idx_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [127:0]   s_q;
  logic [127:0]   out_data_q;

  // One shared round datapath; FINAL taps it before InvMixColumns.
  logic [127:0] isr, isb, ark, imc;

  inv_shift_rows  u_isr (.state_i(s_q), .state_o(isr));
  inv_sub_bytes   u_isb (.state_i(isr), .state_o(isb));
  add_round_key   u_ark (.state_i(isb), .key_i(rk), .state_o(ark));
  inv_mix_columns u_imc (.state_i(ark), .state_o(imc));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= NR4;
      rk_idx_q    <= NR4;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready rises on the first edge after reset release.
          in_ready_q <= 1'b1;
          rk_idx_q   <= NR4;
          if (in_valid && in_ready_q) begin
            s_q        <= in_data ^ rk;
            cnt_q      <= NR4 - 4'd1;
            rk_idx_q   <= NR4 - 4'd1;
            in_ready_q <= 1'b0;
            state_q    <= (NR4 == 4'd1) ? FINAL : ROUND;
          end
        end
        ROUND: begin
          s_q      <= imc;
          cnt_q    <= cnt_q - 4'd1;
          // The key index tracks the counter; it reaches 0 exactly as FINAL is entered.
          rk_idx_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= FINAL;
          end
        end
        FINAL: begin
          out_data_q  <= ark;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            rk_idx_q    <= NR4;
            cnt_q       <= NR4;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign rk_idx    = rk_idx_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative AES decryption core: one 128-bit ciphertext block in, one plaintext block out.
- Performs one inverse round per clock over a single state register, using InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns.
- Round keys are pre-expanded and held in a key store external to this block; the core selects the key through rk_idx.
- Sits opposite the encryption round chain. FIPS-197 byte order: byte 0 = bits [127:120], column-major.

Parameters:
- NR, 10, number of rounds. Legal values 10, 12, 14; any other value is a synthesis error. Round keys are 128-bit for all values.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ciphertext valid.
- in_ready  out  1  core can accept a block.
- in_data  in  128  ciphertext.
- rk_idx  out  4  round-key index presented to the key store.
- rk  in  128  round key rk_idx, returned combinationally in the same cycle.
- out_valid  out  1  plaintext valid.
- out_ready  in  1  consumer accepts plaintext.
- out_data  out  128  plaintext.

Behaviour:
- Reset (asynchronous assert, synchronous release) forces:
  - state=IDLE, round counter=NR, rk_idx=NR.
  - in_ready=0 while rst is high, then 1 in IDLE.
  - out_valid=0, out_data=0, state register=0.
- A reset mid-block aborts the block; no out_valid is produced for it.
- States: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - in_ready=1, rk_idx=NR.
  - On in_valid&&in_ready: state register <= in_data ^ rk. Counter <= NR-1. Go to ROUND, or to FINAL if NR-1==0 (never true for legal NR).
- ROUND:
  - in_ready=0, rk_idx=counter.
  - State register <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(s)), rk)).
  - Counter decrements by 1.
  - When the counter is 1 during this cycle, next state is FINAL.
- FINAL:
  - rk_idx=0.
  - out_data <= AddRoundKey(InvSubBytes(InvShiftRows(s)), rk). out_valid <= 1. Go to DONE.
- DONE:
  - out_valid=1; out_data is held stable until out_ready.
  - On out_ready: out_valid <= 0, go to IDLE, rk_idx <= NR.
  - in_valid is ignored in DONE: in_ready=0, no back-to-back overlap.
- Latency: from the accept edge to out_valid high is NR edges (10 for AES-128). Accept edge = edge 0; out_valid rises at edge NR.
- Minimum initiation interval: NR+2 cycles per block, including the IDLE cycle after the output handshake.
- rk_idx is a registered/decoded function of state only. It never depends combinationally on in_valid or out_ready.
- in_data is sampled only on the accept edge; later changes have no effect.
- The key store may change contents only while in_ready=1. Changes at other times are undefined; the bench does not exercise this.
- Inverse transforms are implemented as submodules InvSubBytes, InvShiftRows, InvMixColumns. AddRoundKey is reused as-is.
- InvMixColumns matrix is {0e,0b,0d,09} in GF(2^8) with polynomial 0x11b.
- InvSubBytes is a 256-entry inverse S-box; InvShiftRows rotates row r right by r.

Test Plan:
- FIPS-197 C.1:
  - Setup: key store expanded from key 000102030405060708090a0b0c0d0e0f. Note rk[10]=13111d7fe3944a17f307a78b4d2b30c5.
  - Stimulus: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: out_data=00112233445566778899aabbccddeeff, out_valid rising exactly 10 edges after accept. Log rk_idx sequence 10,9,...,1,0.
- FIPS-197 B:
  - Setup: key 2b7e151628aed2a6abf7158809cf4f3c.
  - Stimulus: ciphertext 3925841d02dc09fbdc118597196a0b32.
  - Required: out_data=3243f6a8885a308d313198a2e0370734.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid; toggle in_valid and in_data throughout.
  - Required: out_data stable, in_ready=0, no second accept. After out_ready pulse: IDLE, in_ready=1 next cycle.
- Back-to-back:
  - Stimulus: C.1 vector then B vector, in_valid held high, out_ready tied 1.
  - Required: both plaintexts correct, accepts spaced exactly 12 cycles apart.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously (between edges) at round 5.
  - Required: outputs clear immediately (out_valid=0, out_data=0, rk_idx=NR). No output for the aborted block. The next C.1 block decrypts correctly.
- NR=14:
  - Setup: AES-256 FIPS-197 C.3 key store.
  - Stimulus: ciphertext 8ea2b7ca516745bfeafc49904b496089.
  - Required: out_data=00112233445566778899aabbccddeeff, latency 14 edges.
